// File: rtl/rle_pixel_decoder.sv
// rle_pixel_decoder: expands run-length-encoded colour tokens into one colour
// per active pixel, using the blank/vsync timing from the VGA timing generator.
// A two-entry token buffer (cur + nxt) lets back-to-back 1-pixel runs sustain
// one pixel per clock.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_FRAME | after reset; no tokens taken, black output until vsync
// RUN        | normal decode: buffer fills in blanking, drains on pixels
// UNDERRUN   | starved at an active pixel; tokens discarded until vsync
module rle_pixel_decoder #(
   parameter int RUN_BITS    = 10,
   parameter int COLOUR_BITS = 6
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            blank,
   input  logic                            hsync_pulse,
   input  logic                            vsync_pulse,
   input  logic [RUN_BITS+COLOUR_BITS-1:0] tok_data,
   input  logic                            tok_valid,
   output logic                            tok_ready,
   output logic                            frame_req,
   output logic [COLOUR_BITS-1:0]          colour,
   output logic                            underrun
);

   typedef enum logic [1:0] {WAIT_FRAME, RUN, UNDERRUN} state_t;

   state_t                 state_q, state_d;
   logic                   cur_v_q, cur_v_d;
   logic [RUN_BITS-1:0]    cur_rem_q, cur_rem_d;
   logic [COLOUR_BITS-1:0] cur_col_q, cur_col_d;
   logic                   nxt_v_q, nxt_v_d;
   logic [RUN_BITS-1:0]    nxt_run_q, nxt_run_d;
   logic [COLOUR_BITS-1:0] nxt_col_q, nxt_col_d;
   logic [COLOUR_BITS-1:0] colour_q, colour_d;
   logic                   frame_req_q;
   logic                   underrun_q, underrun_d;

   logic [RUN_BITS-1:0]    tok_run;
   logic [COLOUR_BITS-1:0] tok_col;
   logic                   cur_retire;
   logic                   accept;

   // Line sync carries no information the decoder needs.
   logic unused_hsync;
   assign unused_hsync = hsync_pulse;

   assign tok_run   = tok_data[RUN_BITS+COLOUR_BITS-1:COLOUR_BITS];
   assign tok_col   = tok_data[COLOUR_BITS-1:0];
   assign colour    = colour_q;
   assign frame_req = frame_req_q;
   assign underrun  = underrun_q;

   // Next-state, buffer update and handshake; vsync overrides everything.
   always_comb begin
      state_d    = state_q;
      cur_v_d    = cur_v_q;
      cur_rem_d  = cur_rem_q;
      cur_col_d  = cur_col_q;
      nxt_v_d    = nxt_v_q;
      nxt_run_d  = nxt_run_q;
      nxt_col_d  = nxt_col_q;
      colour_d   = '0;
      underrun_d = underrun_q;
      tok_ready  = 1'b0;
      cur_retire = (state_q == RUN) && !blank && cur_v_q && (cur_rem_q == '0);

      case (state_q)
         RUN:      tok_ready = !nxt_v_q || cur_retire;
         UNDERRUN: tok_ready = 1'b1;
         default:  tok_ready = 1'b0;
      endcase
      if (vsync_pulse) begin
         tok_ready = 1'b0;
      end
      accept = tok_valid && tok_ready;

      if (vsync_pulse) begin
         cur_v_d = 1'b0;
         nxt_v_d = 1'b0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (blank) begin
            // Blanking only fills the buffer; cur is always filled first.
            if (!cur_v_q) begin
               if (nxt_v_q) begin
                  cur_v_d   = 1'b1;
                  cur_rem_d = nxt_run_q;
                  cur_col_d = nxt_col_q;
                  nxt_v_d   = 1'b0;
               end else if (accept) begin
                  cur_v_d   = 1'b1;
                  cur_rem_d = tok_run;
                  cur_col_d = tok_col;
               end
            end else if (accept) begin
               nxt_v_d   = 1'b1;
               nxt_run_d = tok_run;
               nxt_col_d = tok_col;
            end
         end else if (!cur_v_q) begin
            underrun_d = 1'b1;
            state_d    = UNDERRUN;
         end else begin
            colour_d = cur_col_q;
            if (cur_rem_q != '0) begin
               cur_rem_d = cur_rem_q - RUN_BITS'(1);
               if (accept) begin
                  nxt_v_d   = 1'b1;
                  nxt_run_d = tok_run;
                  nxt_col_d = tok_col;
               end
            end else if (nxt_v_q) begin
               cur_rem_d = nxt_run_q;
               cur_col_d = nxt_col_q;
               nxt_v_d   = accept;
               if (accept) begin
                  nxt_run_d = tok_run;
                  nxt_col_d = tok_col;
               end
            end else if (accept) begin
               // Bypass: a retiring run with an empty nxt reloads straight
               // from the token so 1-pixel runs never leave a bubble.
               cur_rem_d = tok_run;
               cur_col_d = tok_col;
            end else begin
               cur_v_d = 1'b0;
            end
         end
      end
   end

   // State, buffer and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= WAIT_FRAME;
         cur_v_q     <= 1'b0;
         cur_rem_q   <= '0;
         cur_col_q   <= '0;
         nxt_v_q     <= 1'b0;
         nxt_run_q   <= '0;
         nxt_col_q   <= '0;
         colour_q    <= '0;
         frame_req_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_v_q     <= cur_v_d;
         cur_rem_q   <= cur_rem_d;
         cur_col_q   <= cur_col_d;
         nxt_v_q     <= nxt_v_d;
         nxt_run_q   <= nxt_run_d;
         nxt_col_q   <= nxt_col_d;
         colour_q    <= colour_d;
         frame_req_q <= vsync_pulse;
         underrun_q  <= underrun_d;
      end
   end

endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Bench for rle_pixel_decoder: directed frames driven through a small raster
// generator, a pixel-queue reference model checked every cycle, and literal
// expectations on captured pixels.
module tb_rle_pixel_decoder;

   localparam int M_WAIT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_UNDER = 2;

   logic        clk;
   logic        reset;
   logic        blank;
   logic        hsync_pulse;
   logic        vsync_pulse;
   logic [15:0] tok_data;
   logic        tok_valid;
   logic        tok_ready;
   logic        frame_req;
   logic [5:0]  colour;
   logic        underrun;

   rle_pixel_decoder #(.RUN_BITS(10), .COLOUR_BITS(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .blank       (blank),
      .hsync_pulse (hsync_pulse),
      .vsync_pulse (vsync_pulse),
      .tok_data    (tok_data),
      .tok_valid   (tok_valid),
      .tok_ready   (tok_ready),
      .frame_req   (frame_req),
      .colour      (colour),
      .underrun    (underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stimulus-owned state.
   logic [15:0] tok_arr [0:1023];
   int          tok_n;
   int          rd;
   bit          src_en;
   int          hold_lo;
   int          hold_hi;
   int          drv_x;
   int          drv_line;
   string       lit_name [0:63];
   int          lit_act  [0:63];
   int          lit_exp  [0:63];
   int          lit_wr;

   // Checker-owned state.
   int          n_chk;
   int          n_err;
   int          lit_rd;
   logic [5:0]  cap [0:7][0:639];
   logic [5:0]  pix [$];
   int          m_mode;
   logic [5:0]  e_col;
   logic        e_fr;
   logic        e_ur;
   int          p_x;
   int          p_line;
   logic        acc_m;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: every accepted token appends run+1 copies of its colour
   // to a pixel queue; each active pixel in RUN pops one, an empty queue is an
   // underrun. Outputs are registered, so expectations apply one cycle later.
   initial begin
      n_chk = 0; n_err = 0; lit_rd = 0;
      m_mode = M_WAIT; e_col = '0; e_fr = 1'b0; e_ur = 1'b0;
      p_x = -1; p_line = 0; acc_m = 1'b0;
      forever begin
         @(negedge clk);
         while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
         end
         if (reset) begin
            chk("reset_colour", int'(colour), 0);
            chk("reset_ready", int'(tok_ready), 0);
            m_mode = M_WAIT;
            pix.delete();
            e_col = '0; e_fr = 1'b0; e_ur = 1'b0;
            p_x = -1;
         end else begin
            chk("colour", int'(colour), int'(e_col));
            chk("frame_req", int'(frame_req), int'(e_fr));
            chk("underrun", int'(underrun), int'(e_ur));
            if (p_x >= 0) cap[p_line][p_x] = colour;
            if (vsync_pulse || m_mode == M_WAIT)
               chk("tok_ready_low", int'(tok_ready), 0);
            else if (m_mode == M_UNDER)
               chk("tok_ready_under", int'(tok_ready), 1);
            acc_m = tok_valid && tok_ready;
            e_fr  = vsync_pulse;
            e_col = '0;
            if (vsync_pulse) begin
               pix.delete();
               m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
               if (!blank) begin
                  if (pix.size() == 0) begin
                     e_ur   = 1'b1;
                     m_mode = M_UNDER;
                  end else begin
                     e_col = pix.pop_front();
                  end
               end
               if (acc_m && m_mode == M_RUN)
                  for (int i = 0; i <= int'(tok_data[15:6]); i++)
                     pix.push_back(tok_data[5:0]);
            end
            p_x    = drv_x;
            p_line = drv_line;
         end
      end
   end

   function automatic logic [15:0] mk(input int run, input int col);
      return {run[9:0], col[5:0]};
   endfunction

   task automatic lit(input string nm, input int a, input int e);
      lit_name[lit_wr] = nm;
      lit_act[lit_wr]  = a;
      lit_exp[lit_wr]  = e;
      lit_wr++;
   endtask

   // One clock: inputs change 1 time unit after the rising edge.
   task automatic tick(input logic b, input logic hs, input logic vs, input int x);
      logic acc_s;
      blank       = b;
      hsync_pulse = hs;
      vsync_pulse = vs;
      drv_x       = x;
      tok_valid   = src_en && (rd < tok_n) && !(x >= hold_lo && x < hold_hi);
      tok_data    = (rd < tok_n) ? tok_arr[rd] : 16'h0000;
      @(negedge clk);
      acc_s = tok_valid && tok_ready;
      @(posedge clk);
      #1;
      if (acc_s) rd++;
   endtask

   task automatic line(input int ln);
      drv_line = ln;
      for (int x = 0; x < 640; x++) tick(1'b0, 1'b0, 1'b0, x);
      for (int i = 0; i < 160; i++) tick(1'b1, (i == 16), 1'b0, -1);
   endtask

   // Frame start with a token already offered in the vsync cycle.
   task automatic new_frame();
      src_en = 1'b0;
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, -1);
      rd     = 0;
      src_en = 1'b1;
      tick(1'b1, 1'b0, 1'b1, -1);
      lit("vsync_no_accept", rd, 0);
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, -1);
   endtask

   initial begin
      reset = 1'b1; blank = 1'b1; hsync_pulse = 1'b0; vsync_pulse = 1'b0;
      tok_valid = 1'b0; tok_data = 16'h0000;
      tok_n = 0; rd = 0; src_en = 1'b0; hold_lo = -1; hold_hi = -1;
      drv_x = -1; drv_line = 0; lit_wr = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset mid-line with tokens pending, then tokens refused until vsync.
      tok_arr[0] = mk(639, 'h30);
      tok_arr[1] = mk(639, 'h0C);
      tok_n = 2;
      new_frame();
      drv_line = 0;
      for (int x = 0; x < 300; x++) tick(1'b0, 1'b0, 1'b0, x);
      reset = 1'b1;
      tick(1'b0, 1'b0, 1'b0, -1);
      tick(1'b0, 1'b0, 1'b0, -1);
      reset = 1'b0;
      lit("rst_colour", int'(colour), 0);
      lit("rst_ready", int'(tok_ready), 0);
      lit("rst_underrun", int'(underrun), 0);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, -1);
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, -1);

      // Two full-line runs; a third token stays buffered into the next vsync.
      tok_arr[0] = mk(639, 'h30);
      tok_arr[1] = mk(639, 'h0C);
      tok_arr[2] = mk(639, 'h2A);
      tok_n = 3;
      new_frame();
      line(0);
      line(1);
      lit("l0_first", int'(cap[0][0]), 'h30);
      lit("l0_last", int'(cap[0][639]), 'h30);
      lit("l1_first", int'(cap[1][0]), 'h0C);
      lit("l1_last", int'(cap[1][639]), 'h0C);

      // Checkerboard of 1-pixel runs; the buffered 0x2A token must be gone.
      for (int i = 0; i < 640; i++) tok_arr[i] = mk(0, (i % 2 == 0) ? 'h3F : 'h00);
      tok_n = 640;
      new_frame();
      line(2);
      lit("cb_x0", int'(cap[2][0]), 'h3F);
      lit("cb_x1", int'(cap[2][1]), 'h00);
      lit("cb_x638", int'(cap[2][638]), 'h3F);
      lit("cb_all_taken", rd, 640);
      lit("cb_underrun", int'(underrun), 0);

      // Run spanning a line boundary.
      tok_arr[0] = mk(599, 'h0C);
      tok_arr[1] = mk(99, 'h03);
      tok_arr[2] = mk(579, 'h30);
      tok_n = 3;
      new_frame();
      line(3);
      line(4);
      lit("span_x599", int'(cap[3][599]), 'h0C);
      lit("span_x600", int'(cap[3][600]), 'h03);
      lit("span_n1_x59", int'(cap[4][59]), 'h03);
      lit("span_n1_x60", int'(cap[4][60]), 'h30);

      // Starvation: valid dropped for x=300..304, first starved pixel is 302.
      for (int i = 0; i < 640; i++) tok_arr[i] = mk(0, (i % 2 == 0) ? 'h3F : 'h00);
      tok_n = 640;
      new_frame();
      hold_lo = 300;
      hold_hi = 305;
      line(5);
      hold_lo = -1;
      hold_hi = -1;
      lit("starve_x300", int'(cap[5][300]), 'h3F);
      lit("starve_x302", int'(cap[5][302]), 'h00);
      lit("starve_x306", int'(cap[5][306]), 'h00);
      lit("starve_flag", int'(underrun), 1);
      lit("starve_discard", rd, 640);

      // Next frame decodes again; the sticky flag remains.
      tok_arr[0] = mk(639, 'h0C);
      tok_n = 1;
      new_frame();
      line(6);
      lit("resume_x0", int'(cap[6][0]), 'h0C);
      lit("resume_x639", int'(cap[6][639]), 'h0C);
      lit("resume_sticky", int'(underrun), 1);

      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, -1);
      if (lit_rd != lit_wr) $display("FAIL literal_drain: got %0d expected %0d", lit_rd, lit_wr);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/rle_pixel_decoder.md
Name: rle_pixel_decoder

Overview:
- Consumes the raster timing outputs (blank, hsync_pulse, vsync_pulse) of the VGA timing generator and an upstream stream of run-length-encoded tokens.
- Expands each token into one colour per active pixel.
- Sits between the RLE token source (SPI/QSPI fetch FIFO) and the output pins.
- Holds a two-entry token buffer so that back-to-back 1-pixel runs sustain one pixel per clock.

Parameters:
- RUN_BITS, 10, width of the run-length field; a run field value of R draws R+1 pixels.
- COLOUR_BITS, 6, width of the colour field (RRGGBB, 2 bits each).

Ports:
- clk  input  1  pixel clock.
- reset  input  1  asynchronous, active-high reset.
- blank  input  1  1 = non-active pixel, from the timing generator.
- hsync_pulse  input  1  one-clock pulse per line; informational only, ignored by the decoder.
- vsync_pulse  input  1  one-clock pulse per frame, during vertical sync; marks the frame start.
- tok_data  input  RUN_BITS+COLOUR_BITS  token: run = tok_data[15:6], colour = tok_data[5:0].
- tok_valid  input  1  token available.
- tok_ready  output  1  decoder accepts the token this cycle; a transfer occurs when tok_valid && tok_ready.
- frame_req  output  1  one-clock pulse telling the upstream to restart the token stream at frame start.
- colour  output  COLOUR_BITS  registered pixel colour.
- underrun  output  1  sticky flag: an active pixel was reached with no token loaded.

Behaviour:
- Reset (asynchronous, active-high) values:
  - colour=0, tok_ready=0, frame_req=0, underrun=0.
  - Both buffer entries invalid, state=WAIT_FRAME.
- Storage:
  - cur entry: rem[RUN_BITS-1:0], col, cur_v.
  - nxt entry: run, col, nxt_v.
- tok_ready:
  - In RUN: tok_ready = !nxt_v || (cur entry is retiring this cycle && nxt_v).
  - tok_ready is a registered-free combinational function of state and buffer flags only, never of tok_valid.
- States:
  - WAIT_FRAME: tok_ready=0; colour=0. On vsync_pulse go to RUN.
  - RUN: normal decode, described below.
  - UNDERRUN: colour=0; tok_ready=1 and accepted tokens are discarded. On vsync_pulse go to RUN.
- Frame start: vsync_pulse in any state does all of the following in one cycle:
  - Flush both entries (cur_v=nxt_v=0).
  - Pulse frame_req on the next cycle.
  - Force tok_ready=0 in the vsync_pulse cycle itself.
  - Tokens offered in that cycle are not consumed.
- RUN, blank=1 cycles:
  - The buffer only fills: if !cur_v, load cur from nxt, or directly from an accepted token when nxt is empty (bypass).
  - Otherwise an accepted token goes to nxt.
  - colour is registered as 0 on the next cycle.
- RUN, blank=0 cycles (active pixel):
  - If cur_v: colour <= cur.col on the next clock, so latency is 1 clock from the blank sample.
  - If cur.rem != 0: rem--.
  - If cur.rem == 0: cur retires and is refilled in the same cycle from nxt; if nxt is empty, from the accepted token (bypass); otherwise cur_v=0.
  - When cur is refilled from nxt, an accepted token in the same cycle loads into nxt.
  - If !cur_v at an active pixel: colour <= 0, underrun <= 1, state -> UNDERRUN.
- Runs may span line and blanking boundaries: rem decrements only on active pixels.
- Simultaneous events: vsync_pulse has priority over every buffer update and token acceptance. blank is assumed 1 whenever vsync_pulse=1.
- underrun clears only on reset.
- Widths:
  - rem holds R; a run field of 0 draws 1 pixel; the maximum run of 1023 draws 1024 pixels.
  - No arithmetic wraps: rem is never decremented at 0.

Test Plan:
- Reset mid-line with tokens pending -> next cycle colour=0, tok_ready=0, underrun=0, state WAIT_FRAME; tok_ready stays 0 until vsync_pulse.
- vsync_pulse -> frame_req high exactly one cycle later. Then feed tokens {run=639, col=0x30} and {run=639, col=0x0C} -> line 0 all 0x30, line 1 all 0x0C, colour delayed 1 clock after blank falls, colour=0 during blanking.
- 640 tokens of run=0 with alternating colours 0x3F/0x00, tok_valid held high -> one token per active clock, no bubble, checkerboard output, underrun=0.
- Token {run=99, col=0x03} presented at x=600 -> 40 pixels at end of line N, remaining 60 at start of line N+1.
- tok_valid dropped for 5 clocks mid-line after the buffer drains -> colour=0 from the first starved pixel, underrun=1 and stays 1; tokens then discarded until the next vsync_pulse; decode resumes correctly in the next frame.
- tok_valid=1 in the same cycle as vsync_pulse -> token not accepted (tok_ready=0); both buffer entries flushed.
